// File: rtl/i2c_slave.sv
// I2C register-access slave: 7-bit address, 8-bit register pointer with auto-increment,
// oversampled from sys_clk (no clock stretching, SDA open-drain via sda_oe).
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h7A
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 4;

    localparam logic [STATE_W-1:0] IDLE      = 4'd0;
    localparam logic [STATE_W-1:0] ADDR      = 4'd1;
    localparam logic [STATE_W-1:0] ADDR_ACK  = 4'd2;
    localparam logic [STATE_W-1:0] REG       = 4'd3;
    localparam logic [STATE_W-1:0] REG_ACK   = 4'd4;
    localparam logic [STATE_W-1:0] WDATA     = 4'd5;
    localparam logic [STATE_W-1:0] WDATA_ACK = 4'd6;
    localparam logic [STATE_W-1:0] RDATA     = 4'd7;
    localparam logic [STATE_W-1:0] RDATA_ACK = 4'd8;
    localparam logic [STATE_W-1:0] IGNORE    = 4'd9;

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               rw_q, rw_d;
    logic               acked_q, acked_d;
    logic               sda_oe_d, busy_d, we_d, re_d;
    logic [7:0]         addr_d, wdata_d;

    logic scl_rise_c, scl_fall_c, start_c, stop_c;

    // SDA edges only count as START/STOP while SCL is steadily high
    assign scl_rise_c = scl_s2 & ~scl_h;
    assign scl_fall_c = ~scl_s2 & scl_h;
    assign start_c    = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_c     = scl_s2 & scl_h & ~sda_h & sda_s2;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        rw_d     = rw_q;
        acked_d  = acked_q;
        sda_oe_d = sda_oe;
        busy_d   = busy;
        addr_d   = reg_addr;
        wdata_d  = reg_wdata;
        we_d     = 1'b0;
        re_d     = 1'b0;

        if (stop_c) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_c) begin
            state_d  = ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG, WDATA: begin
                    if (scl_rise_c && cnt_q < 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s2};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall_c && cnt_q == 4'd8) begin
                        cnt_d = '0;
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                state_d  = ADDR_ACK;
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                rw_d     = shift_q[0];
                            end else begin
                                state_d = IGNORE;
                            end
                        end else if (state_q == REG) begin
                            state_d  = REG_ACK;
                            addr_d   = shift_q;
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d  = WDATA_ACK;
                            we_d     = 1'b1;
                            wdata_d  = shift_q;
                            sda_oe_d = 1'b1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_c) begin
                        if (rw_q) begin
                            state_d  = RDATA;
                            re_d     = 1'b1;
                            shift_d  = reg_rdata;
                            sda_oe_d = ~reg_rdata[7];
                            cnt_d    = 4'd1;
                        end else begin
                            state_d  = REG;
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                        end
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    if (scl_fall_c) begin
                        state_d  = WDATA;
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                        if (state_q == WDATA_ACK) begin
                            addr_d = reg_addr + 8'd1;
                        end
                    end
                end
                RDATA: begin
                    // cnt counts bits already placed on the bus
                    if (scl_fall_c) begin
                        if (cnt_q == 4'd8) begin
                            state_d  = RDATA_ACK;
                            sda_oe_d = 1'b0;
                            acked_d  = 1'b0;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise_c) begin
                        addr_d = reg_addr + 8'd1;
                        if (sda_s2) begin
                            state_d = IGNORE;
                        end else begin
                            acked_d = 1'b1;
                        end
                    end else if (scl_fall_c && acked_q) begin
                        state_d  = RDATA;
                        re_d     = 1'b1;
                        shift_d  = reg_rdata;
                        sda_oe_d = ~reg_rdata[7];
                        cnt_d    = 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            scl_s1    <= 1'b1;
            scl_s2    <= 1'b1;
            scl_h     <= 1'b1;
            sda_s1    <= 1'b1;
            sda_s2    <= 1'b1;
            sda_h     <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            acked_q   <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            scl_s1    <= scl;
            scl_s2    <= scl_s1;
            scl_h     <= scl_s2;
            sda_s1    <= sda_i;
            sda_s2    <= sda_s1;
            sda_h     <= sda_s2;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            acked_q   <= acked_d;
            sda_oe    <= sda_oe_d;
            busy      <= busy_d;
            reg_addr  <= addr_d;
            reg_wdata <= wdata_d;
            reg_we    <= we_d;
            reg_re    <= re_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, register-file peripheral and a
// pointer/register reference model; table vectors, corner sequences, random traffic.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int Q = 6;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy;

    logic [7:0] regs [256] = '{default: 8'h00};
    logic [7:0] exp_regs [256] = '{default: 8'h00};
    logic [7:0] exp_ptr = 8'h00;
    logic [7:0] wbuf [4];
    logic [7:0] rbuf [4];
    logic [15:0] we_q [$];
    int re_cnt = 0, oe_cnt = 0, busy_cnt = 0;
    int checks = 0, errors = 0;

    typedef struct {
        logic [7:0] ptr;
        int         n;
        logic [7:0] d0, d1, d2;
        logic [7:0] exp_after;
    } wvec_t;
    wvec_t tbl [5];

    assign sda_bus   = m_sda & ~sda_oe;
    assign reg_rdata = regs[reg_addr];

    always #5 sys_clk = ~sys_clk;

    i2c_slave dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .scl      (scl_m),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata),
        .busy     (busy)
    );

    // Peripheral side: register file plus strobe/activity counters
    always @(negedge sys_clk) begin
        if (reg_we) begin
            we_q.push_back({reg_addr, reg_wdata});
            regs[reg_addr] <= reg_wdata;
        end
        if (reg_re) re_cnt <= re_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (busy)   busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic qw();
        repeat (Q) @(negedge sys_clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qw();
        scl_m = 1'b1; qw();
        m_sda = 1'b0; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qw();
        scl_m = 1'b1; qw();
        m_sda = 1'b1; qw();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; qw();
        scl_m = 1'b1; qw(); qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; qw();
        scl_m = 1'b1; qw();
        ack = ~sda_bus; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic read_byte(input logic ack_m, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; qw();
            scl_m = 1'b1; qw();
            b[i] = sda_bus; qw();
            scl_m = 1'b0; qw();
        end
        send_bit(~ack_m);
        m_sda = 1'b1;
    endtask

    // Full write transaction; checks ACKs, strobes and the pointer against the model
    task automatic check_write(input logic [7:0] p, input int n, input logic [7:0] exp_after);
        logic ack;
        logic [15:0] e;
        i2c_start();
        write_byte(8'hF4, ack);
        check("wr_addr_ack", 32'(ack), 32'd1);
        check("wr_busy", 32'(busy), 32'd1);
        write_byte(p, ack);
        check("wr_reg_ack", 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], ack);
            check("wr_data_ack", 32'(ack), 32'd1);
        end
        i2c_stop();
        qw();
        check("wr_we_count", 32'(we_q.size()), 32'(n));
        if (we_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                e = we_q.pop_front();
                check("wr_we_addr", 32'(e[15:8]), 32'(8'(p + 8'(i))));
                check("wr_we_data", 32'(e[7:0]), 32'(wbuf[i]));
                exp_regs[8'(p + 8'(i))] = wbuf[i];
            end
        end
        we_q.delete();
        exp_ptr = 8'(p + 8'(n));
        check("wr_ptr_after", 32'(reg_addr), 32'(exp_after));
        check("wr_busy_after", 32'(busy), 32'd0);
    endtask

    // Combined-format read: set pointer, repeated START, n bytes, NACK on the last
    task automatic do_read(input logic [7:0] p, input int n);
        logic ack;
        i2c_start();
        write_byte(8'hF4, ack);
        check("rd_waddr_ack", 32'(ack), 32'd1);
        write_byte(p, ack);
        check("rd_reg_ack", 32'(ack), 32'd1);
        i2c_start();
        write_byte(8'hF5, ack);
        check("rd_raddr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) read_byte(i != n - 1, rbuf[i]);
        qw();
        check("rd_release_after_nack", 32'(sda_oe), 32'd0);
        i2c_stop();
        qw();
        exp_ptr = 8'(p + 8'(n));
    endtask

    task automatic check_mismatch(input logic [7:0] a, input logic [7:0] d);
        logic ack;
        int oe0, bz0;
        oe0 = oe_cnt;
        bz0 = busy_cnt;
        i2c_start();
        write_byte(a, ack);
        check("mm_addr_nack", 32'(ack), 32'd0);
        write_byte(d, ack);
        check("mm_data_nack", 32'(ack), 32'd0);
        i2c_stop();
        qw();
        check("mm_no_oe", 32'(oe_cnt - oe0), 32'd0);
        check("mm_no_busy", 32'(busy_cnt - bz0), 32'd0);
        check("mm_no_we", 32'(we_q.size()), 32'd0);
        check("mm_ptr", 32'(reg_addr), 32'(exp_ptr));
        we_q.delete();
    endtask

    initial begin
        logic ack;
        int re0, op, n;
        logic [7:0] p, b;

        tbl[0] = '{8'h05, 1, 8'h01, 8'h00, 8'h00, 8'h06};
        tbl[1] = '{8'hFF, 2, 8'h11, 8'h22, 8'h00, 8'h01};
        tbl[2] = '{8'h10, 2, 8'hA5, 8'h3C, 8'h00, 8'h12};
        tbl[3] = '{8'h80, 3, 8'h00, 8'hFF, 8'h5A, 8'h83};
        tbl[4] = '{8'h30, 0, 8'h00, 8'h00, 8'h00, 8'h30};

        repeat (5) @(negedge sys_clk);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        check("rst_we_re", 32'({reg_we, reg_re}), 32'd0);
        rst = 1'b0;
        qw();

        for (int t = 0; t < 5; t++) begin
            wbuf[0] = tbl[t].d0;
            wbuf[1] = tbl[t].d1;
            wbuf[2] = tbl[t].d2;
            check_write(tbl[t].ptr, tbl[t].n, tbl[t].exp_after);
        end

        re0 = re_cnt;
        do_read(8'h10, 2);
        check("comb_byte0", 32'(rbuf[0]), 32'hA5);
        check("comb_byte1", 32'(rbuf[1]), 32'h3C);
        check("comb_re_pulses", 32'(re_cnt - re0), 32'd2);
        check("comb_ptr", 32'(reg_addr), 32'h12);

        check_mismatch(8'hA0, 8'h55);

        // STOP after four data bits: partial byte must be dropped
        i2c_start();
        write_byte(8'hF4, ack);
        write_byte(8'h20, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        qw();
        check("abort_no_we", 32'(we_q.size()), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_oe", 32'(sda_oe), 32'd0);
        check("abort_ptr", 32'(reg_addr), 32'h20);
        we_q.delete();

        // Reset in the middle of a read byte (register 0x40 is 0x00 so SDA is being pulled)
        i2c_start();
        write_byte(8'hF4, ack);
        write_byte(8'h40, ack);
        i2c_start();
        write_byte(8'hF5, ack);
        for (int i = 0; i < 4; i++) begin
            m_sda = 1'b1; qw();
            scl_m = 1'b1; qw(); qw();
            scl_m = 1'b0; qw();
        end
        check("rst_pre_oe", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        @(negedge sys_clk);
        check("rst_mid_oe", 32'(sda_oe), 32'd0);
        check("rst_mid_ptr", 32'(reg_addr), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        qw();
        i2c_stop();
        qw();
        we_q.delete();
        wbuf[0] = 8'h99;
        check_write(8'h07, 1, 8'h08);

        for (int it = 0; it < 24; it++) begin
            op = int'($urandom_range(0, 2));
            p  = 8'($urandom);
            if (op == 0) begin
                n = int'($urandom_range(0, 3));
                for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                check_write(p, n, 8'(p + 8'(n)));
            end else if (op == 1) begin
                n = int'($urandom_range(1, 3));
                re0 = re_cnt;
                do_read(p, n);
                for (int i = 0; i < n; i++)
                    check("rand_rd_byte", 32'(rbuf[i]), 32'(exp_regs[8'(p + 8'(i))]));
                check("rand_rd_re", 32'(re_cnt - re0), 32'(n));
                check("rand_rd_ptr", 32'(reg_addr), 32'(exp_ptr));
            end else begin
                b = 8'($urandom);
                if (b[7:1] == 7'h7A) b = 8'h22;
                check_mismatch(b, p);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
